dfe_core_out_buffer: RTL and testbench

Output stage for the next-generation DFE core. It decouples the filter chain output (valid-only, no backpressure) from a ready/valid downstream consumer through a first-word-fall-through (FWFT) FIFO. It also aggregates per-stage overflow/underflow flags from a parametrised number of filter stages into sticky status, saturating event counters, an overrun detector and an interrupt line. It sits after the last decimation stage (CIC) and replaces the purely combinational OR of stage flags.

---
 rtl/dfe_core_out_buffer.sv | 124 ++++++++++++
 tb/tb_dfe_core_out_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dfe_core_out_buffer.sv
// Output stage of the DFE core: FWFT sample FIFO towards a ready/valid consumer, plus
// aggregation of per-stage overflow/underflow flags into sticky status, counters and irq.
module dfe_core_out_buffer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned LVL_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [NUM_STAGES-1:0] stage_ovf,
   input  logic [NUM_STAGES-1:0] stage_udf,
   input  logic                  status_clr,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [LVL_WIDTH-1:0]  fifo_level,
   output logic [NUM_STAGES-1:0] sticky_ovf,
   output logic [NUM_STAGES-1:0] sticky_udf,
   output logic [CNT_WIDTH-1:0]  ovf_cnt,
   output logic [CNT_WIDTH-1:0]  udf_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic                  overrun,
   output logic                  irq
);

   localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);
   localparam logic [LVL_WIDTH-1:0] LvlFull = LVL_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CntMax  = '1;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_WIDTH-1:0]  level_q;
   logic                  pop, push, drop, any_ovf, any_udf;

   logic [NUM_STAGES-1:0] sticky_ovf_q, sticky_udf_q;
   logic [CNT_WIDTH-1:0]  ovf_cnt_q, udf_cnt_q, drop_cnt_q;
   logic                  overrun_q, irq_q;

   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign out_valid = (level_q != '0);
   assign pop       = out_valid & out_ready;
   assign push      = in_valid & ((level_q != LvlFull) | pop);
   assign drop      = in_valid & (level_q == LvlFull) & ~pop;
   assign any_ovf   = |stage_ovf;
   assign any_udf   = |stage_udf;

   assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level = level_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
         end
         if (push && !pop) begin
            level_q <= level_q + LVL_WIDTH'(1);
         end else if (pop && !push) begin
            level_q <= level_q - LVL_WIDTH'(1);
         end
      end
   end

   // On status_clr an event in the same cycle wins: sticky set, counter loaded with 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_ovf_q <= '0;
         sticky_udf_q <= '0;
         ovf_cnt_q    <= '0;
         udf_cnt_q    <= '0;
         drop_cnt_q   <= '0;
         overrun_q    <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         if (status_clr) begin
            sticky_ovf_q <= stage_ovf;
            sticky_udf_q <= stage_udf;
            ovf_cnt_q    <= CNT_WIDTH'(any_ovf);
            udf_cnt_q    <= CNT_WIDTH'(any_udf);
            drop_cnt_q   <= CNT_WIDTH'(drop);
            overrun_q    <= drop;
         end else begin
            sticky_ovf_q <= sticky_ovf_q | stage_ovf;
            sticky_udf_q <= sticky_udf_q | stage_udf;
            if (any_ovf && (ovf_cnt_q != CntMax)) begin
               ovf_cnt_q <= ovf_cnt_q + CNT_WIDTH'(1);
            end
            if (any_udf && (udf_cnt_q != CntMax)) begin
               udf_cnt_q <= udf_cnt_q + CNT_WIDTH'(1);
            end
            if (drop && (drop_cnt_q != CntMax)) begin
               drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            end
            overrun_q <= overrun_q | drop;
         end
         irq_q <= (|sticky_ovf_q) | (|sticky_udf_q) | overrun_q;
      end
   end

   assign sticky_ovf = sticky_ovf_q;
   assign sticky_udf = sticky_udf_q;
   assign ovf_cnt    = ovf_cnt_q;
   assign udf_cnt    = udf_cnt_q;
   assign drop_cnt   = drop_cnt_q;
   assign overrun    = overrun_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_dfe_core_out_buffer.sv
// Bench for dfe_core_out_buffer: directed scenarios then random traffic against a queue-based
// reference model; a negedge monitor scoreboards every handshake.
module tb_dfe_core_out_buffer;

   localparam int unsigned DW = 16;
   localparam int unsigned NS = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW = 4;
   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [NS-1:0] stage_ovf = '0;
   logic [NS-1:0] stage_udf = '0;
   logic          status_clr = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [LW-1:0] fifo_level;
   logic [NS-1:0] sticky_ovf, sticky_udf;
   logic [CW-1:0] ovf_cnt, udf_cnt, drop_cnt;
   logic          overrun, irq;

   dfe_core_out_buffer #(
      .DATA_WIDTH(DW),
      .NUM_STAGES(NS),
      .FIFO_DEPTH(DEPTH),
      .CNT_WIDTH (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .stage_ovf (stage_ovf),
      .stage_udf (stage_udf),
      .status_clr(status_clr),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .fifo_level(fifo_level),
      .sticky_ovf(sticky_ovf),
      .sticky_udf(sticky_udf),
      .ovf_cnt   (ovf_cnt),
      .udf_cnt   (udf_cnt),
      .drop_cnt  (drop_cnt),
      .overrun   (overrun),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference model state
   logic [DW-1:0] mq[$];     // model FIFO contents
   logic [DW-1:0] exp_q[$];  // scoreboard of samples still owed to the consumer
   logic [NS-1:0] m_sovf, m_sudf;
   int            m_ovf_cnt, m_udf_cnt, m_drop_cnt;
   bit            m_overrun, m_irq;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int sat_inc(input int c);
      return (c >= CNT_MAX) ? CNT_MAX : c + 1;
   endfunction

   task automatic check_all();
      chk("level", int'(fifo_level), mq.size());
      chk("out_valid", int'(out_valid), int'(mq.size() > 0));
      if (mq.size() == 0) chk("empty_data", int'(out_data), 0);
      else chk("head_data", int'(out_data), int'(mq[0]));
      chk("sticky_ovf", int'(sticky_ovf), int'(m_sovf));
      chk("sticky_udf", int'(sticky_udf), int'(m_sudf));
      chk("ovf_cnt", int'(ovf_cnt), m_ovf_cnt);
      chk("udf_cnt", int'(udf_cnt), m_udf_cnt);
      chk("drop_cnt", int'(drop_cnt), m_drop_cnt);
      chk("overrun", int'(overrun), int'(m_overrun));
      chk("irq", int'(irq), int'(m_irq));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check after the edge.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [NS-1:0] ov,
                        input logic [NS-1:0] ud, input bit clr, input bit rdy, input bit rst);
      bit pop, acc, drp, irq_n;
      in_valid = v; in_data = d; stage_ovf = ov; stage_udf = ud;
      status_clr = clr; out_ready = rdy; rst_n = ~rst;
      if (rst) begin
         mq.delete(); exp_q.delete();
         m_sovf = '0; m_sudf = '0;
         m_ovf_cnt = 0; m_udf_cnt = 0; m_drop_cnt = 0;
         m_overrun = 0; m_irq = 0;
      end else begin
         irq_n = (m_sovf != 0) || (m_sudf != 0) || m_overrun;
         pop = (mq.size() > 0) && rdy;
         acc = v && ((mq.size() < DEPTH) || pop);
         drp = v && !acc;
         if (pop) void'(mq.pop_front());
         if (acc) begin mq.push_back(d); exp_q.push_back(d); end
         if (clr) begin
            m_sovf = ov; m_sudf = ud;
            m_ovf_cnt = (ov != 0) ? 1 : 0;
            m_udf_cnt = (ud != 0) ? 1 : 0;
            m_drop_cnt = drp ? 1 : 0;
            m_overrun = drp;
         end else begin
            m_sovf |= ov; m_sudf |= ud;
            if (ov != 0) m_ovf_cnt = sat_inc(m_ovf_cnt);
            if (ud != 0) m_udf_cnt = sat_inc(m_udf_cnt);
            if (drp) m_drop_cnt = sat_inc(m_drop_cnt);
            m_overrun = m_overrun || drp;
         end
         m_irq = irq_n;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Scoreboard monitor: every handshake must deliver the oldest owed sample.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      logic [NS-1:0] rov, rud;
      cycle(0, '0, '0, '0, 0, 0, 1);

      // In-order FWFT delivery with hold under backpressure
      cycle(1, 16'h1234, '0, '0, 0, 0, 0);
      chk("t1_first_valid", int'(out_valid), 1);
      cycle(1, 16'h8000, '0, '0, 0, 0, 0);
      cycle(1, 16'h7FFF, '0, '0, 0, 0, 0);
      chk("t1_level3", int'(fifo_level), 3);
      cycle(0, '0, '0, '0, 0, 0, 0);
      chk("t1_hold", int'(out_data), 16'h1234);
      for (int i = 0; i < 3; i++) cycle(0, '0, '0, '0, 0, 1, 0);
      chk("t1_drained", int'(out_valid), 0);

      // Overfill: two drops, overrun, irq one cycle later
      for (int i = 0; i < 10; i++) cycle(1, DW'($urandom), '0, '0, 0, 0, 0);
      chk("t2_level", int'(fifo_level), 8);
      chk("t2_drop_cnt", int'(drop_cnt), 2);
      chk("t2_overrun", int'(overrun), 1);
      chk("t2_irq", int'(irq), 1);

      // Push into full FIFO with simultaneous pop
      cycle(1, 16'hABCD, '0, '0, 0, 1, 0);
      chk("t3_level", int'(fifo_level), 8);
      chk("t3_no_drop", int'(drop_cnt), 2);
      for (int i = 0; i < 8; i++) cycle(0, '0, '0, '0, 0, 1, 0);

      // Sticky flags, counters, clear-vs-event priority
      cycle(0, '0, '0, '0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, '0, 4'b0100, (i == 0) ? 4'b0001 : 4'b0000, 0, 0, 0);
      chk("t4_sovf", int'(sticky_ovf), 4'b0100);
      chk("t4_sudf", int'(sticky_udf), 4'b0001);
      chk("t4_ovf_cnt", int'(ovf_cnt), 5);
      chk("t4_udf_cnt", int'(udf_cnt), 1);
      cycle(0, '0, 4'b0010, '0, 1, 0, 0);
      chk("t4_clr_sovf", int'(sticky_ovf), 4'b0010);
      chk("t4_clr_ovf_cnt", int'(ovf_cnt), 1);
      chk("t4_clr_udf_cnt", int'(udf_cnt), 0);

      // Counter saturation
      for (int i = 0; i < 20; i++) cycle(0, '0, 4'b1000, '0, 0, 0, 0);
      chk("t5_sat", int'(ovf_cnt), CNT_MAX);

      // Reset mid-stream
      for (int i = 0; i < 5; i++) cycle(1, DW'($urandom), 4'b0001, 4'b0010, 0, 0, 0);
      cycle(0, '0, '0, '0, 0, 0, 1);
      chk("t6_level", int'(fifo_level), 0);
      chk("t6_irq", int'(irq), 0);
      cycle(1, 16'h5A5A, '0, '0, 0, 0, 0);
      chk("t6_valid", int'(out_valid), 1);
      chk("t6_data", int'(out_data), 16'h5A5A);
      cycle(0, '0, '0, '0, 0, 1, 0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rov = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
         rud = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
         cycle($urandom_range(0, 9) < 7, DW'($urandom), rov, rud,
               $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 149) == 0);
      end

      for (int i = 0; i < 12; i++) cycle(0, '0, '0, '0, 0, 1, 0);
      chk("final_drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
